// File: rtl/cic_i.sv
// Variable-rate CIC interpolator: N combs at the input rate, a zero-stuffing
// upsampler, then N integrators at the clock rate. Valid-only streaming ports.
module cic_i #(
   parameter int INP_DW  = 16,
   parameter int OUT_DW  = 20,
   parameter int RATE_DW = 16,
   parameter int CIC_R   = 4,
   parameter int CIC_N   = 3,
   parameter int CIC_M   = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic signed [INP_DW-1:0]  s_axis_in_tdata,
   input  logic                      s_axis_in_tvalid,
   input  logic        [RATE_DW-1:0] s_axis_rate_tdata,
   input  logic                      s_axis_rate_tvalid,
   output logic signed [OUT_DW-1:0]  m_axis_out_tdata,
   output logic                      m_axis_out_tvalid,
   output logic                      overrun
);

   localparam int W = INP_DW + $clog2((CIC_R * CIC_M) ** CIC_N / CIC_R);
   localparam logic [RATE_DW-1:0] R_MAX = RATE_DW'(CIC_R);

   typedef enum logic {IDLE, BURST} state_t;

   logic signed [W-1:0] in_ext;
   assign in_ext = W'(s_axis_in_tdata);

   for (genvar j = 0; j < CIC_N; j++) begin : g_comb
      logic signed [W-1:0]       x;
      logic                      xv;
      logic signed [W-1:0]       q;
      logic                      v;
      logic [CIC_M*W-1:0]        dl;

      if (j == 0) begin : g_src_in
         assign x  = in_ext;
         assign xv = s_axis_in_tvalid;
      end else begin : g_src_prev
         assign x  = g_comb[j-1].q;
         assign xv = g_comb[j-1].v;
      end

      // Delay line shifts only on strobed samples, oldest entry in the top slot.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            q  <= '0;
            v  <= 1'b0;
            dl <= '0;
         end else begin
            v <= xv;
            if (xv) begin
               q  <= x - $signed(dl[CIC_M*W-1 -: W]);
               dl <= (CIC_M*W)'({dl, x});
            end
         end
      end
   end

   state_t              state, state_d;
   logic [RATE_DW-1:0]  ph, ph_d;
   logic [RATE_DW-1:0]  cur_r, cur_r_d;
   logic [RATE_DW-1:0]  pend_r;
   logic [RATE_DW-1:0]  rate_clamped;
   logic signed [W-1:0] up_q, up_q_d;
   logic                up_v, up_v_d;
   logic                ovr_d;
   logic signed [W-1:0] comb_out;
   logic                comb_out_v;

   assign comb_out   = g_comb[CIC_N-1].q;
   assign comb_out_v = g_comb[CIC_N-1].v;

   always_comb begin
      rate_clamped = s_axis_rate_tdata;
      if (s_axis_rate_tdata == '0)
         rate_clamped = RATE_DW'(1);
      else if (s_axis_rate_tdata > R_MAX)
         rate_clamped = R_MAX;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         ph      <= '0;
         cur_r   <= R_MAX;
         pend_r  <= R_MAX;
         up_q    <= '0;
         up_v    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_d;
         ph      <= ph_d;
         cur_r   <= cur_r_d;
         up_q    <= up_q_d;
         up_v    <= up_v_d;
         overrun <= ovr_d;
         if (s_axis_rate_tvalid)
            pend_r <= rate_clamped;
      end
   end

   // A new comb sample always wins; cutting a burst short raises the sticky flag.
   always_comb begin
      state_d = state;
      ph_d    = ph;
      cur_r_d = cur_r;
      up_q_d  = up_q;
      up_v_d  = 1'b0;
      ovr_d   = overrun;
      if (comb_out_v) begin
         up_q_d  = comb_out;
         up_v_d  = 1'b1;
         ph_d    = RATE_DW'(1);
         cur_r_d = pend_r;
         state_d = BURST;
         if (state == BURST && ph < cur_r)
            ovr_d = 1'b1;
      end else if (state == BURST) begin
         if (ph < cur_r) begin
            up_q_d = '0;
            up_v_d = 1'b1;
            ph_d   = ph + RATE_DW'(1);
         end else begin
            state_d = IDLE;
         end
      end
   end

   for (genvar i = 0; i < CIC_N; i++) begin : g_int
      logic signed [W-1:0] x;
      logic                xv;
      logic signed [W-1:0] acc;
      logic                v;

      if (i == 0) begin : g_src_up
         assign x  = up_q;
         assign xv = up_v;
      end else begin : g_src_prev
         assign x  = g_int[i-1].acc;
         assign xv = g_int[i-1].v;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            acc <= '0;
            v   <= 1'b0;
         end else begin
            v <= xv;
            if (xv)
               acc <= acc + x;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_axis_out_tdata  <= '0;
         m_axis_out_tvalid <= 1'b0;
      end else begin
         m_axis_out_tvalid <= g_int[CIC_N-1].v;
         if (g_int[CIC_N-1].v)
            m_axis_out_tdata <= g_int[CIC_N-1].acc[W-1 -: OUT_DW];
      end
   end

endmodule

// File: tb/tb_cic_i.sv
// Directed bench for cic_i at default parameters (R=4, N=3, M=1, W=20).
module tb_cic_i;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic signed [15:0] s_axis_in_tdata = '0;
   logic               s_axis_in_tvalid = 1'b0;
   logic        [15:0] s_axis_rate_tdata = '0;
   logic               s_axis_rate_tvalid = 1'b0;
   logic signed [19:0] m_axis_out_tdata;
   logic               m_axis_out_tvalid;
   logic               overrun;

   int nvec = 0;
   int nerr = 0;

   int imp_tab[10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
   int step4[6]    = '{1, 3, 6, 10, 13, 15};
   int ovr_tab[6]  = '{1, 3, 3, 1, -3, -9};

   cic_i #(
      .INP_DW (16),
      .OUT_DW (20),
      .RATE_DW(16),
      .CIC_R  (4),
      .CIC_N  (3),
      .CIC_M  (1)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .s_axis_in_tdata   (s_axis_in_tdata),
      .s_axis_in_tvalid  (s_axis_in_tvalid),
      .s_axis_rate_tdata (s_axis_rate_tdata),
      .s_axis_rate_tvalid(s_axis_rate_tvalid),
      .m_axis_out_tdata  (m_axis_out_tdata),
      .m_axis_out_tvalid (m_axis_out_tvalid),
      .overrun           (overrun)
   );

   always #5 clk = ~clk;

   task automatic cycle(input logic v, input int d, input logic rv, input int rd);
      s_axis_in_tvalid   = v;
      s_axis_in_tdata    = 16'(d);
      s_axis_rate_tvalid = rv;
      s_axis_rate_tdata  = 16'(rd);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      s_axis_in_tvalid   = 1'b0;
      s_axis_rate_tvalid = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      s_axis_in_tvalid   = 1'b0;
      s_axis_rate_tvalid = 1'b0;
      reset_n = 1'b0;
      #1;
      nvec++;
      if (m_axis_out_tvalid !== 1'b0) begin
         nerr++;
         $display("FAIL reset tvalid: got %b want 0", m_axis_out_tvalid);
      end
      nvec++;
      if (m_axis_out_tdata !== 20'sd0) begin
         nerr++;
         $display("FAIL reset tdata: got %0d want 0", m_axis_out_tdata);
      end
      nvec++;
      if (overrun !== 1'b0) begin
         nerr++;
         $display("FAIL reset overrun: got %b want 0", overrun);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_impulse();
      logic        ev;
      logic [19:0] ed;
      int          j;
      for (int i = 0; i < 63; i++) begin
         cycle(i % 4 == 0 && i < 48, (i == 0) ? 1 : 0, 1'b0, 0);
         j  = i - 7;
         ev = (j >= 0 && j < 48);
         ed = (j >= 0 && j < 10) ? 20'(imp_tab[j]) : 20'd0;
         nvec++;
         if (m_axis_out_tvalid !== ev) begin
            nerr++;
            $display("FAIL impulse tvalid @%0d: got %b want %b", i, m_axis_out_tvalid, ev);
         end
         nvec++;
         if (m_axis_out_tdata !== ed) begin
            nerr++;
            $display("FAIL impulse tdata @%0d: got %0d want %0d", i, m_axis_out_tdata, $signed(ed));
         end
      end
   endtask

   task automatic test_dc();
      logic        ev;
      logic [19:0] ed;
      int          j;
      do_reset();
      for (int i = 0; i < 96; i++) begin
         cycle(i % 4 == 0 && i < 80, 100, 1'b0, 0);
         j  = i - 7;
         ev = (j >= 0 && j < 80);
         if (j < 0)      ed = 20'd0;
         else if (j < 6) ed = 20'(100 * step4[j]);
         else            ed = 20'd1600;
         nvec++;
         if (m_axis_out_tvalid !== ev) begin
            nerr++;
            $display("FAIL dc tvalid @%0d: got %b want %b", i, m_axis_out_tvalid, ev);
         end
         nvec++;
         if (m_axis_out_tdata !== ed) begin
            nerr++;
            $display("FAIL dc tdata @%0d: got %0d want %0d", i, m_axis_out_tdata, $signed(ed));
         end
         nvec++;
         if (overrun !== 1'b0) begin
            nerr++;
            $display("FAIL dc overrun @%0d: got %b want 0", i, overrun);
         end
      end
   endtask

   // Zeros at R=4, rate 2 written on the cycle of a burst start, then DC 100 every 2.
   task automatic test_rate_change();
      logic        v, ev;
      logic [19:0] ed;
      for (int i = 0; i < 86; i++) begin
         v = (i < 32 && i % 4 == 0) || (i >= 32 && i <= 70 && i % 2 == 0);
         if (i == 0) do_reset();
         cycle(v, (i >= 32) ? 100 : 0, i == 31, 2);
         ev = (i >= 7 && i <= 78);
         if (i < 39)       ed = 20'd0;
         else if (i == 39) ed = 20'd100;
         else if (i == 40) ed = 20'd300;
         else              ed = 20'd400;
         nvec++;
         if (m_axis_out_tvalid !== ev) begin
            nerr++;
            $display("FAIL rate_change tvalid @%0d: got %b want %b", i, m_axis_out_tvalid, ev);
         end
         nvec++;
         if (m_axis_out_tdata !== ed) begin
            nerr++;
            $display("FAIL rate_change tdata @%0d: got %0d want %0d", i, m_axis_out_tdata, $signed(ed));
         end
      end
   endtask

   task automatic test_rate_one();
      logic        ev;
      logic [19:0] ed;
      do_reset();
      for (int i = 0; i < 41; i++) begin
         cycle(i < 30, 100, i == 0, 0);
         ev = (i >= 7 && i <= 36);
         ed = (i >= 7) ? 20'd100 : 20'd0;
         nvec++;
         if (m_axis_out_tvalid !== ev) begin
            nerr++;
            $display("FAIL rate_one tvalid @%0d: got %b want %b", i, m_axis_out_tvalid, ev);
         end
         nvec++;
         if (m_axis_out_tdata !== ed) begin
            nerr++;
            $display("FAIL rate_one tdata @%0d: got %0d want %0d", i, m_axis_out_tdata, $signed(ed));
         end
         nvec++;
         if (overrun !== 1'b0) begin
            nerr++;
            $display("FAIL rate_one overrun @%0d: got %b want 0", i, overrun);
         end
      end
   endtask

   task automatic test_rate_clamp();
      logic        ev;
      logic [19:0] ed;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(i == 2, 1, i < 2, (i == 0) ? 2 : 9);
         ev = (i >= 9 && i <= 12);
         if (i < 9)        ed = 20'd0;
         else if (i <= 12) ed = 20'(imp_tab[i-9]);
         else              ed = 20'd10;
         nvec++;
         if (m_axis_out_tvalid !== ev) begin
            nerr++;
            $display("FAIL rate_clamp tvalid @%0d: got %b want %b", i, m_axis_out_tvalid, ev);
         end
         nvec++;
         if (m_axis_out_tdata !== ed) begin
            nerr++;
            $display("FAIL rate_clamp tdata @%0d: got %0d want %0d", i, m_axis_out_tdata, $signed(ed));
         end
      end
   endtask

   task automatic test_overrun();
      logic        ev, eo;
      logic [19:0] ed;
      do_reset();
      for (int i = 0; i < 31; i++) begin
         cycle(i == 0 || i == 2, (i == 0) ? 1 : 0, 1'b0, 0);
         eo = (i >= 5);
         ev = (i >= 7 && i <= 12);
         if (i < 7)        ed = 20'd0;
         else if (i <= 12) ed = 20'(ovr_tab[i-7]);
         else              ed = 20'(-9);
         nvec++;
         if (overrun !== eo) begin
            nerr++;
            $display("FAIL overrun flag @%0d: got %b want %b", i, overrun, eo);
         end
         nvec++;
         if (m_axis_out_tvalid !== ev) begin
            nerr++;
            $display("FAIL overrun tvalid @%0d: got %b want %b", i, m_axis_out_tvalid, ev);
         end
         nvec++;
         if (m_axis_out_tdata !== ed) begin
            nerr++;
            $display("FAIL overrun tdata @%0d: got %0d want %0d", i, m_axis_out_tdata, $signed(ed));
         end
      end
   endtask

   task automatic test_wrap();
      logic        ev;
      logic [19:0] ed;
      int          j;
      do_reset();
      for (int i = 0; i < 816; i++) begin
         cycle(i % 4 == 0 && i < 800, -32768, 1'b0, 0);
         j  = i - 7;
         ev = (j >= 0 && j < 800);
         if (j < 0)      ed = 20'd0;
         else if (j < 6) ed = 20'(-32768 * step4[j]);
         else            ed = 20'(-524288);
         nvec++;
         if (m_axis_out_tvalid !== ev) begin
            nerr++;
            $display("FAIL wrap tvalid @%0d: got %b want %b", i, m_axis_out_tvalid, ev);
         end
         nvec++;
         if (m_axis_out_tdata !== ed) begin
            nerr++;
            $display("FAIL wrap tdata @%0d: got %0d want %0d", i, m_axis_out_tdata, $signed(ed));
         end
      end
   endtask

   task automatic test_reset_midburst();
      do_reset();
      for (int i = 0; i < 13; i++)
         cycle(i % 4 == 0, (i == 0) ? 1 : 0, 1'b0, 0);
      #2;
      s_axis_in_tvalid = 1'b0;
      reset_n = 1'b0;
      #1;
      nvec++;
      if (m_axis_out_tvalid !== 1'b0) begin
         nerr++;
         $display("FAIL midburst async tvalid: got %b want 0", m_axis_out_tvalid);
      end
      nvec++;
      if (m_axis_out_tdata !== 20'sd0) begin
         nerr++;
         $display("FAIL midburst async tdata: got %0d want 0", m_axis_out_tdata);
      end
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 0, 1'b0, 0);
         nvec++;
         if (m_axis_out_tvalid !== 1'b0 || m_axis_out_tdata !== 20'sd0) begin
            nerr++;
            $display("FAIL midburst idle @%0d: got v=%b d=%0d want v=0 d=0", i, m_axis_out_tvalid, m_axis_out_tdata);
         end
      end
      test_impulse();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      test_reset();
      test_impulse();
      test_dc();
      test_rate_change();
      test_rate_one();
      test_rate_clamp();
      test_overrun();
      test_reset();
      test_wrap();
      test_reset_midburst();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
